// File: rtl/ground_pkg.sv
// ground_pkg: shared state encoding, geometry defaults and colour constant for the ground scroller.
package ground_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2} gstate_t;
  localparam int DEF_SCREEN_W = 640;
  localparam int DEF_TILE_W = 16;
  localparam int DEF_TILE_H = 16;
  localparam logic [7:0] ZERO_COLOR = 8'd0;
endpackage

// File: rtl/ground_scroll_ctrl_if.sv
// ground_scroll_ctrl_if: pixel-in, tile ROM and ground-pixel-out bundle.
interface ground_scroll_ctrl_if;
  logic [10:0] hx;
  logic [10:0] vy;
  logic pix_valid;
  logic [10:0] tile_x;
  logic [10:0] tile_y;
  logic [7:0] rom_r;
  logic [7:0] rom_g;
  logic [7:0] rom_b;
  logic rom_mask;
  logic [7:0] o_r;
  logic [7:0] o_g;
  logic [7:0] o_b;
  logic o_hit;
  logic o_valid;
  modport master (
    output hx, vy, pix_valid, rom_r, rom_g, rom_b, rom_mask,
    input tile_x, tile_y, o_r, o_g, o_b, o_hit, o_valid
  );
  modport slave (
    input hx, vy, pix_valid, rom_r, rom_g, rom_b, rom_mask,
    output tile_x, tile_y, o_r, o_g, o_b, o_hit, o_valid
  );
endinterface

// File: rtl/ground_scroll_fsm.sv
// ground_scroll_fsm: frame-synchronous IDLE/RUN/HALT control, pending clear and scroll wrap.
// Optional GROUND_SPEEDUP_EN adds a 3-bit level that increases the per-frame step.
module ground_scroll_fsm
  import ground_pkg::*;
#(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SPEED = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_start,
  input  logic run,
  input  logic clr,
`ifdef GROUND_SPEEDUP_EN
  input  logic [2:0] level,
`endif
  output gstate_t state,
  output logic [9:0] scroll_pos
);
  gstate_t state_n;
  logic clr_pend;
  logic pend;
  logic [10:0] step;
  logic [10:0] sum;
  logic [9:0] scroll_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      scroll_pos <= '0;
      clr_pend <= 1'b0;
    end else begin
      state <= state_n;
      scroll_pos <= scroll_n;
      clr_pend <= frame_start ? 1'b0 : pend;
    end
  end
  always_comb begin
    pend = clr_pend | clr;
    state_n = state;
    if (frame_start) state_n = pend ? IDLE : run ? RUN : (state == IDLE) ? IDLE : HALT;
  end
  // advancing is keyed on the state being entered, so the IDLE->RUN frame already moves
  always_comb begin
`ifdef GROUND_SPEEDUP_EN
    step = 11'(SPEED) + 11'(level);
`else
    step = 11'(SPEED);
`endif
    sum = {1'b0, scroll_pos} + step;
    scroll_n = !frame_start ? scroll_pos :
               pend ? 10'd0 :
               (state_n == RUN) ? ((sum >= 11'(SCREEN_W)) ? 10'(sum - 11'(SCREEN_W)) : sum[9:0]) :
               scroll_pos;
  end
endmodule

// File: rtl/ground_scroll_ctrl.sv
// ground_scroll_ctrl: maps band pixels to scrolled tile coordinates and aligns registered ROM data, 3-cycle latency.
// Optional GROUND_SPEEDUP_EN adds the level input forwarded to the scroll FSM.
module ground_scroll_ctrl
  import ground_pkg::*;
#(
  parameter int GROUND_Y = 400,
  parameter int GROUND_H = 16,
  parameter int TILE_W = DEF_TILE_W,
  parameter int TILE_H = DEF_TILE_H,
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SPEED = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_start,
  input  logic run,
  input  logic clr,
`ifdef GROUND_SPEEDUP_EN
  input  logic [2:0] level,
`endif
  ground_scroll_ctrl_if.slave bus,
  output logic [9:0] scroll_pos,
  output logic [1:0] state
);
  gstate_t st;
  logic in_band;
  logic s1_valid, s1_band, s2_valid, s2_band, hit;
  logic [10:0] s1_hx;
  logic [10:0] col_sum;
  if (GROUND_H > TILE_H) begin : g_chk_h
    $error("GROUND_H exceeds TILE_H");
  end
  if ((TILE_W & (TILE_W - 1)) != 0) begin : g_chk_w
    $error("TILE_W not a power of two");
  end
  ground_scroll_fsm #(.SCREEN_W(SCREEN_W), .SPEED(SPEED)) u_fsm (
    .clk(clk),
    .rst(rst),
    .frame_start(frame_start),
    .run(run),
    .clr(clr),
`ifdef GROUND_SPEEDUP_EN
    .level(level),
`endif
    .state(st),
    .scroll_pos(scroll_pos)
  );
  assign state = st;
  always_comb begin
    in_band = bus.pix_valid && (bus.vy >= 11'(GROUND_Y)) && (bus.vy < 11'(GROUND_Y + GROUND_H));
    col_sum = s1_hx + 11'(scroll_pos);
    hit = s2_band & bus.rom_mask;
  end
  // tile_y feeds the ROM row latch; tile_x selects the column once that row is out
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_band <= 1'b0;
      s1_hx <= '0;
      bus.tile_y <= '0;
      s2_valid <= 1'b0;
      s2_band <= 1'b0;
      bus.tile_x <= '0;
      bus.o_valid <= 1'b0;
      bus.o_hit <= 1'b0;
      bus.o_r <= ZERO_COLOR;
      bus.o_g <= ZERO_COLOR;
      bus.o_b <= ZERO_COLOR;
    end else begin
      s1_valid <= bus.pix_valid;
      s1_band <= in_band;
      s1_hx <= bus.hx;
      bus.tile_y <= in_band ? bus.vy - 11'(GROUND_Y) : '0;
      s2_valid <= s1_valid;
      s2_band <= s1_band;
      bus.tile_x <= s1_band ? (col_sum & 11'(TILE_W - 1)) : '0;
      bus.o_valid <= s2_valid;
      bus.o_hit <= hit;
      bus.o_r <= hit ? bus.rom_r : ZERO_COLOR;
      bus.o_g <= hit ? bus.rom_g : ZERO_COLOR;
      bus.o_b <= hit ? bus.rom_b : ZERO_COLOR;
    end
  end
endmodule

// File: doc/ground_scroll_ctrl.md
# ground_scroll_ctrl

Controller that sequences the 16×16 repeating grass tile sprite ROM across the ground band of the screen and scrolls it horizontally once per frame. It sits between the VGA timing generator and the tile ROM. It maps each screen pixel to tile-local coordinates plus a scroll offset, then aligns the ROM's registered row output with a pixel-valid pipeline. The game FSM starts, halts and clears scrolling; all changes take effect only at frame boundaries to avoid tearing.

## Interface
- `GROUND_Y`, 400: first screen row of the ground band.
- `GROUND_H`, 16: ground band height in rows. Must be ≤ `TILE_H`.
- `TILE_W`, 16: tile width. Must be a power of two.
- `TILE_H`, 16: tile height.
- `SCREEN_W`, 640: scroll wrap modulus.
- `SPEED`, 2: pixels scrolled per frame while running.

Ports:
- `clk` in 1: pixel clock, sole clock.
- `rst` in 1: synchronous, active-high reset.
- `frame_start` in 1: one-cycle pulse at the start of vertical blanking.
- `run` in 1: level request from the game FSM to scroll.
- `clr` in 1: pulse requesting a return to IDLE with scroll position 0.
- `hx` in 11: screen column.
- `vy` in 11: screen row.
- `pix_valid` in 1: `hx`/`vy` are in the active area.
- `tile_x` out 11: ROM column address.
- `tile_y` out 11: ROM row address.
- `rom_r`, `rom_g`, `rom_b` in 8 each: ROM colour.
- `rom_mask` in 1: ROM alpha.
- `o_r`, `o_g`, `o_b` out 8 each: ground pixel colour.
- `o_hit` out 1: pixel belongs to opaque ground.
- `o_valid` out 1: delayed `pix_valid`.
- `scroll_pos` out 10: current scroll offset, 0..`SCREEN_W`-1.
- `state` out 2: IDLE=0, RUN=1, HALT=2.

## Operation
- FSM updates only on `frame_start`:
  - IDLE→RUN if `run`.
  - RUN→HALT if `!run`.
  - HALT→RUN if `run`.
- `clr` sets a `clr_pend` flag. At the next `frame_start`, a pending clear wins over `run`: state becomes IDLE, `scroll_pos` becomes 0 and the flag is cleared.
- A `clr` arriving in the same cycle as `frame_start` is applied at that `frame_start`.
- Scroll position:
  - In RUN, at each `frame_start`, `scroll_pos` ← `scroll_pos`+step.
  - If the sum is ≥ `SCREEN_W`, `SCREEN_W` is subtracted.
  - The sum is computed 11 bits wide before the compare.
  - The new value is used from the cycle after `frame_start`.
  - IDLE and HALT hold `scroll_pos`.
- Band test: a pixel is in the band when `pix_valid` is set and `GROUND_Y` ≤ `vy` < `GROUND_Y`+`GROUND_H`.
- Address mapping:
  - Column = (`hx`+`scroll_pos`) mod `TILE_W`, taken as the low log2(`TILE_W`) bits.
  - Row = `vy`−`GROUND_Y`.
  - Upper address bits are zero.
- Out of band: `tile_x`/`tile_y` are driven to 0, `o_hit`=0 and `o_r`/`o_g`/`o_b`=0.
- In band: `o_hit` = `rom_mask`. RGB passes through from the ROM when `o_hit`=1, otherwise 0.

## Timing
- The ROM latches its row on `clk` from `tile_y` and selects the column combinationally from `tile_x`. The pipeline is built around that:
  - S1: register `tile_y`, band flag and valid.
  - S2: register `tile_x` from the column computed in S1. ROM data is now valid for the S1 row.
  - S3: register the outputs.
- Latency is exactly 3 cycles from `hx`/`vy`/`pix_valid` to `o_*`/`o_valid`. It is constant regardless of state.
- Pipeline flags are cleared on reset. Registered address fields are 0 after reset; the S1 column is taken from S1-registered `hx`.
- Reset values:
  - `state`=IDLE, `scroll_pos`=0, `clr_pend`=0.
  - `tile_x`=`tile_y`=0.
  - `o_r`/`o_g`/`o_b`=0, `o_hit`=0, `o_valid`=0.
- `rst` mid-frame takes effect on the next edge. No output glitches beyond the already-defined zero values.
- `frame_start` arriving while `pix_valid`=1 is still legal; the scroll change is visible to pixels sampled after the edge.

## Configuration
- `GROUND_SPEEDUP_EN` defined:
  - Adds input `level` (3 bits).
  - Step = `SPEED`+`level`, with `level` sampled at `frame_start`.
  - Max step is `SPEED`+7; this must be < `SCREEN_W`.
- `GROUND_SPEEDUP_EN` undefined: no `level` port, and step = `SPEED`.

## Structure
- Package `ground_pkg`:
  - State encoding IDLE/RUN/HALT.
  - Default values for `SCREEN_W`, `TILE_W`, `TILE_H`.
  - Zero-colour constant.
- Sub-module `ground_scroll_fsm` holds the state register, `clr_pend` and the `scroll_pos` update/wrap logic.
- The top level holds the 3-stage address/data pipeline.

## Test plan
- Reset, then `run`=1 with 3 `frame_start` pulses (`SPEED`=2) → `state`=RUN after the first pulse; `scroll_pos` = 2, 4, 6.
- `scroll_pos`=638, RUN, `frame_start` → `scroll_pos`=0. From 639 → 1.
- `scroll_pos`=5, `hx`=12, `vy`=403, `pix_valid`=1 → 3 cycles later `tile_x`=1 and `tile_y`=3 have been driven, `o_valid`=1, `o_hit`=`rom_mask`, RGB = ROM values.
- `vy`=399 or `vy`=416 → `o_hit`=0, RGB=0, and `o_valid` follows `pix_valid` with 3-cycle delay.
- `clr` pulse mid-frame while RUN, `run` held 1 → no change until `frame_start`, then `state`=IDLE and `scroll_pos`=0. The next `frame_start` moves the FSM to RUN.
- With `GROUND_SPEEDUP_EN`, `level`=3 in RUN → `scroll_pos` advances by 5 per frame. `rst` asserted mid-line → all outputs 0 next cycle.
